// File: rtl/multdiv_sequencer.sv
// Execute-stage sequencer for the multi-cycle mul/div unit: latches operands,
// issues the start pulse, stalls the front end and presents the result to X/M.
module multdiv_sequencer #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] insn_x,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    output logic        stall,
    output logic        bubble_xm,
    output logic        md_done,
    output logic [31:0] md_out,
    output logic        md_write_exception
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        opa_q, opa_d;
    logic [31:0]        opb_q, opb_d;
    logic [31:0]        res_q, res_d;
    logic               exc_q, exc_d;
    logic               div_q, div_d;
    logic               mult_pulse_q, mult_pulse_d;
    logic               div_pulse_q, div_pulse_d;

    logic is_md;
    logic is_div;
    logic unused_insn_bits;

    assign is_md  = (insn_x[31:27] == 5'b00000) &&
                    ((insn_x[6:2] == 5'b00110) || (insn_x[6:2] == 5'b00111));
    assign is_div = insn_x[2];
    assign unused_insn_bits = ^{insn_x[26:7], insn_x[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            res_q        <= '0;
            exc_q        <= 1'b0;
            div_q        <= 1'b0;
            mult_pulse_q <= 1'b0;
            div_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            res_q        <= res_d;
            exc_q        <= exc_d;
            div_q        <= div_d;
            mult_pulse_q <= mult_pulse_d;
            div_pulse_q  <= div_pulse_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        res_d        = res_q;
        exc_d        = exc_q;
        div_d        = div_q;
        mult_pulse_d = 1'b0;
        div_pulse_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (is_md) begin
                    opa_d        = operandA;
                    opb_d        = operandB;
                    div_d        = is_div;
                    cnt_d        = '0;
                    mult_pulse_d = ~is_div;
                    div_pulse_d  = is_div;
                    state_d      = S_BUSY;
                end
            end
            S_BUSY: begin
                // A real completion beats the timeout when both land together.
                if (md_ready) begin
                    res_d   = md_result;
                    exc_d   = md_exception;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    res_d   = '0;
                    exc_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ctrl_mult = mult_pulse_q;
    assign ctrl_div  = div_pulse_q;
    assign md_opA    = opa_q;
    assign md_opB    = opb_q;

    assign stall     = ~reset & (((state_q == S_IDLE) & is_md) | (state_q == S_BUSY));
    assign bubble_xm = stall;

    assign md_done            = (state_q == S_DONE);
    assign md_write_exception = md_done & exc_q;

    always_comb begin
        md_out = '0;
        if (md_done) begin
            if (exc_q) md_out = div_q ? 32'd5 : 32'd4;
            else       md_out = res_q;
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: per-cycle expectations derived from the
// operation timeline, checked every cycle, plus literal checks on key results.
module tb_multdiv_sequencer;

    localparam int TIMEOUT = 40;
    localparam logic [31:0] INSN_MUL  = 32'h0000_0018;
    localparam logic [31:0] INSN_DIV  = 32'h0000_001C;
    localparam logic [31:0] INSN_ADD  = 32'h0000_0000;
    localparam logic [31:0] INSN_SUB  = 32'h0000_0004;
    localparam logic [31:0] INSN_ADDI = 32'h2800_0018;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] insn_x, operandA, operandB, md_result;
    logic        md_exception, md_ready;
    logic        ctrl_mult, ctrl_div, stall, bubble_xm, md_done, md_write_exception;
    logic [31:0] md_opA, md_opB, md_out;

    multdiv_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .insn_x(insn_x),
        .operandA(operandA), .operandB(operandB),
        .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
        .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .md_opA(md_opA), .md_opB(md_opB),
        .stall(stall), .bubble_xm(bubble_xm),
        .md_done(md_done), .md_out(md_out), .md_write_exception(md_write_exception)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic        chk_en = 1'b0;
    logic        e_stall, e_mult, e_div, e_done, e_wexc;
    logic [31:0] e_out, lat_a, lat_b;

    int          t_det_g = 0;
    int          busy_stall_cnt = 0;
    int          mult_cnt = 0, div_cnt = 0, done_cnt = 0;
    int          last_pulse_cyc = 0, last_done_cyc = 0;
    logic [31:0] last_done_out = '0;
    logic        last_done_we = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the expectations set for this cycle.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("stall",     {31'd0, stall},     {31'd0, e_stall});
            chk("bubble_xm", {31'd0, bubble_xm}, {31'd0, e_stall});
            chk("ctrl_mult", {31'd0, ctrl_mult}, {31'd0, e_mult});
            chk("ctrl_div",  {31'd0, ctrl_div},  {31'd0, e_div});
            chk("md_done",   {31'd0, md_done},   {31'd0, e_done});
            chk("md_out",    md_out, e_out);
            chk("md_wexc",   {31'd0, md_write_exception}, {31'd0, e_wexc});
            chk("md_opA",    md_opA, lat_a);
            chk("md_opB",    md_opB, lat_b);
        end
        if (!reset) begin
            if (stall && cyc > t_det_g) busy_stall_cnt++;
            if (ctrl_mult) begin mult_cnt++; last_pulse_cyc = cyc; end
            if (ctrl_div)  begin div_cnt++;  last_pulse_cyc = cyc; end
            if (md_done) begin
                done_cnt++;
                last_done_cyc = cyc;
                last_done_out = md_out;
                last_done_we  = md_write_exception;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                         input logic rdy, input logic [31:0] res, input logic exc);
        insn_x = insn; operandA = a; operandB = b;
        md_ready = rdy; md_result = res; md_exception = exc;
    endtask

    task automatic expect_out(input logic st, input logic mu, input logic dv,
                              input logic dn, input logic [31:0] out, input logic we);
        e_stall = st; e_mult = mu; e_div = dv; e_done = dn; e_out = out; e_wexc = we;
    endtask

    // One complete mul/div: detect, BUSY cycles, DONE. L < 0 means no md_ready (timeout).
    task automatic do_op(input logic dv, input logic [31:0] a, input logic [31:0] b,
                         input int L, input logic [31:0] res, input logic exc);
        logic [31:0] insn;
        logic [31:0] code;
        logic        timed;
        int          nb;
        insn  = dv ? INSN_DIV : INSN_MUL;
        timed = (L < 0);
        nb    = timed ? TIMEOUT : L + 1;
        tick();
        drive(insn, a, b, 1'b0, 32'hDEAD_0000, 1'b0);
        expect_out(1, 0, 0, 0, 32'd0, 0);
        t_det_g = cyc;
        busy_stall_cnt = 0;
        for (int k = 0; k < nb; k++) begin
            tick();
            lat_a = a;
            lat_b = b;
            if (!timed && k == L) drive(insn, ~a, ~b, 1'b1, res, exc);
            else                  drive(insn, ~a, ~b, 1'b0, 32'hBAD0_0000 | k, 1'b1);
            expect_out(1, (k == 0) && !dv, (k == 0) && dv, 0, 32'd0, 0);
        end
        tick();
        drive(insn, ~a, ~b, 1'b1, 32'h1234_5678, 1'b1);
        code = (timed || exc) ? (dv ? 32'd5 : 32'd4) : res;
        expect_out(0, 0, 0, 1, code, timed || exc);
        @(negedge clock);
        #1;
    endtask

    task automatic idle(input int n, input logic [31:0] insn, input logic rdy);
        for (int i = 0; i < n; i++) begin
            tick();
            drive(insn, $urandom, $urandom, rdy, $urandom, 1'b1);
            expect_out(0, 0, 0, 0, 32'd0, 0);
        end
        @(negedge clock);
        #1;
    endtask

    initial begin
        int d1, m0, dv0, dn0;
        reset = 1'b1;
        lat_a = '0; lat_b = '0;
        drive(INSN_ADD, 0, 0, 1'b0, 0, 1'b0);
        expect_out(0, 0, 0, 0, 32'd0, 0);
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        idle(2, INSN_ADD, 1'b0);

        // mul 7*6, ready 3 cycles after the pulse
        do_op(0, 32'd7, 32'd6, 3, 32'd42, 0);
        chk("t1_opA", md_opA, 32'd7);
        chk("t1_opB", md_opB, 32'd6);
        chk("t1_out", last_done_out, 32'd42);
        chk("t1_we", {31'd0, last_done_we}, 32'd0);
        chk("t1_busy_stall", busy_stall_cnt, 32'd4);
        chk("t1_mult_pulses", mult_cnt, 32'd1);
        idle(2, INSN_ADD, 1'b0);

        // div by zero with exception, then mul overflow with L=0
        do_op(1, 32'd20, 32'd0, 1, 32'd0, 1);
        chk("t2_div_code", last_done_out, 32'd5);
        chk("t2_div_we", {31'd0, last_done_we}, 32'd1);
        chk("t2_div_pulses", div_cnt, 32'd1);
        idle(1, INSN_ADD, 1'b0);
        do_op(0, 32'h0001_0000, 32'h0001_0000, 0, 32'd0, 1);
        chk("t2_mul_code", last_done_out, 32'd4);
        chk("t2_l0_busy_stall", busy_stall_cnt, 32'd1);

        // back-to-back muls: only the DONE cycle is unstalled between them
        idle(1, INSN_ADD, 1'b0);
        do_op(0, 32'd3, 32'd5, 2, 32'd15, 0);
        chk("t3_out1", last_done_out, 32'd15);
        d1 = last_done_cyc;
        do_op(0, 32'd2, 32'd9, 2, 32'd18, 0);
        chk("t3_out2", last_done_out, 32'd18);
        chk("t3_detect_gap", t_det_g - d1, 32'd1);
        chk("t3_pulse_gap", last_pulse_cyc - d1, 32'd2);

        // timeout, then md_ready on the timeout cycle
        idle(1, INSN_ADD, 1'b0);
        do_op(0, 32'd1, 32'd2, -1, 32'd0, 0);
        chk("t4_timeout_latency", last_done_cyc - t_det_g, 32'd41);
        chk("t4_timeout_code", last_done_out, 32'd4);
        idle(1, INSN_ADD, 1'b0);
        do_op(0, 32'd9, 32'd9, TIMEOUT - 1, 32'd81, 0);
        chk("t4_tie_out", last_done_out, 32'd81);
        chk("t4_tie_we", {31'd0, last_done_we}, 32'd0);
        idle(1, INSN_ADD, 1'b0);
        do_op(1, 32'd8, 32'd3, -1, 32'd0, 0);
        chk("t4_div_timeout_code", last_done_out, 32'd5);

        // reset during BUSY, then a stray md_ready
        idle(1, INSN_ADD, 1'b0);
        dn0 = done_cnt;
        tick();
        drive(INSN_MUL, 32'd11, 32'd12, 1'b0, 0, 1'b0);
        expect_out(1, 0, 0, 0, 32'd0, 0);
        tick();
        lat_a = 32'd11; lat_b = 32'd12;
        drive(INSN_MUL, 0, 0, 1'b0, 0, 1'b0);
        expect_out(1, 1, 0, 0, 32'd0, 0);
        tick();
        expect_out(1, 0, 0, 0, 32'd0, 0);
        tick();
        chk_en = 1'b0;
        reset = 1'b1;
        drive(INSN_ADD, 0, 0, 1'b0, 0, 1'b0);
        tick();
        reset = 1'b0;
        chk_en = 1'b1;
        lat_a = '0; lat_b = '0;
        drive(INSN_ADD, 0, 0, 1'b1, 32'd99, 1'b0);
        expect_out(0, 0, 0, 0, 32'd0, 0);
        idle(4, INSN_ADD, 1'b1);
        chk("t5_no_done", done_cnt - dn0, 32'd0);

        // non-mul/div instructions with stray md_ready
        m0 = mult_cnt; dv0 = div_cnt; dn0 = done_cnt;
        idle(4, INSN_ADD, 1'b1);
        idle(3, INSN_SUB, 1'b1);
        idle(3, INSN_ADDI, 1'b1);
        chk("t6_no_mult", mult_cnt - m0, 32'd0);
        chk("t6_no_div", div_cnt - dv0, 32'd0);
        chk("t6_no_done", done_cnt - dn0, 32'd0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
